// File: rtl/switch_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce_pkg
// Purpose  : Shared constants, per-channel state type and counter sizing.
// Revision : 1.0
// ============================================================================
package switch_debounce_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int SIM_DEBOUNCE_CYCLES     = 4;
   localparam int DEFAULT_SYNC_STAGES     = 2;

   // State is implied by the counter: zero means the output agrees with the input.
   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_SETTLE = 1'b1
   } deb_state_t;

   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One switch input: synchroniser, stability counter, edge strobes.
// Revision : 1.0
// ============================================================================
module debounce_channel
   import switch_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic sw_clean,
   output logic rise,
   output logic fall,
   output logic settling
);

   localparam int               CNT_W     = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_clean;
   logic                   r_rise;
   logic                   r_fall;

   logic                   w_synced;
   deb_state_t             w_state;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   w_clean_nxt;
   logic                   w_rise_nxt;
   logic                   w_fall_nxt;

   assign w_synced = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_clean <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], sw_raw};
         r_cnt   <= w_cnt_nxt;
         r_clean <= w_clean_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   always_comb begin
      w_state     = (r_cnt != '0) ? ST_SETTLE : ST_STABLE;
      w_cnt_nxt   = r_cnt;
      w_clean_nxt = r_clean;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;

      if (w_synced == r_clean) begin
         // Agreement at any point, including mid-settle, discards the timing.
         w_cnt_nxt = '0;
      end else if (r_cnt == c_cnt_max) begin
         w_cnt_nxt   = '0;
         w_clean_nxt = w_synced;
         w_rise_nxt  = w_synced;
         w_fall_nxt  = ~w_synced;
      end else begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   assign sw_clean = r_clean;
   assign rise     = r_rise;
   assign fall     = r_fall;
   assign settling = (w_state == ST_SETTLE);

endmodule
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce
// Purpose  : Debounces N_CH raw board switches into clean levels and strobes.
// Revision : 1.0
// ============================================================================
module switch_debounce
   import switch_debounce_pkg::*;
#(
   parameter int N_CH            = 2,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] sw_raw,
   output logic [N_CH-1:0] sw_clean,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] settling
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .sw_raw   (sw_raw[i]),
         .sw_clean (sw_clean[i]),
         .rise     (rise[i]),
         .fall     (fall[i]),
         .settling (settling[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debounce
// Purpose  : Directed and random checks of switch_debounce against a window model.
// Revision : 1.0
// ============================================================================
module tb_switch_debounce;
   import switch_debounce_pkg::*;

   localparam int N  = 2;
   localparam int SS = DEFAULT_SYNC_STAGES;
   localparam int D0 = SIM_DEBOUNCE_CYCLES;
   localparam int D1 = 1;
   localparam int HN = 1024;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] raw0  = '0;
   logic [N-1:0] raw1  = '0;
   logic [N-1:0] clean0, rise0, fall0, settle0;
   logic [N-1:0] clean1, rise1, fall1, settle1;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   switch_debounce #(.N_CH(N), .DEBOUNCE_CYCLES(D0), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n), .sw_raw(raw0),
      .sw_clean(clean0), .rise(rise0), .fall(fall0), .settling(settle0)
   );

   switch_debounce #(.N_CH(N), .DEBOUNCE_CYCLES(D1), .SYNC_STAGES(SS)) dut1 (
      .clk(clk), .rst_n(rst_n), .sw_raw(raw1),
      .sw_clean(clean1), .rise(rise1), .fall(fall1), .settling(settle1)
   );

   // Reference: a level is accepted once the last D synchronised samples,
   // all taken after the previous acceptance, disagree with the current output.
   int           dcyc [2] = '{D0, D1};
   bit           hist [2][N][HN];
   int           nedge [2];
   int           lastflip [2][N];
   logic [N-1:0] m_clean [2];
   logic [N-1:0] m_rise [2];
   logic [N-1:0] m_fall [2];
   logic [N-1:0] m_settle [2];

   function automatic bit synced_at(int i, int c, int k);
      if (k - SS < 1) return 1'b0;
      return hist[i][c][(k - SS - 1) % HN];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         nedge[i]    = 0;
         m_clean[i]  = '0;
         m_rise[i]   = '0;
         m_fall[i]   = '0;
         m_settle[i] = '0;
         for (int c = 0; c < N; c++) lastflip[i][c] = 0;
      end
   endtask

   task automatic model_edge();
      bit accept;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         nedge[i]++;
         for (int c = 0; c < N; c++) begin
            hist[i][c][(nedge[i] - 1) % HN] = (i == 0) ? raw0[c] : raw1[c];
            m_rise[i][c] = 1'b0;
            m_fall[i][c] = 1'b0;
            accept = (nedge[i] - lastflip[i][c] >= dcyc[i]);
            if (accept)
               for (int k = nedge[i] - dcyc[i] + 1; k <= nedge[i]; k++)
                  if (synced_at(i, c, k) == m_clean[i][c]) accept = 1'b0;
            if (accept) begin
               m_clean[i][c]  = ~m_clean[i][c];
               m_rise[i][c]   = m_clean[i][c];
               m_fall[i][c]   = ~m_clean[i][c];
               lastflip[i][c] = nedge[i];
            end
            m_settle[i][c] = (synced_at(i, c, nedge[i]) != m_clean[i][c]);
         end
      end
   endtask

   function automatic logic [4*N-1:0] model_vec(int i);
      return {m_clean[i], m_rise[i], m_fall[i], m_settle[i]};
   endfunction

   function automatic logic [4*N-1:0] dut_vec(int i);
      if (i == 0) return {clean0, rise0, fall0, settle0};
      return {clean1, rise1, fall1, settle1};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Vector layout {clean[1:0], rise[1:0], fall[1:0], settling[1:0]}.
   task automatic test_reset();
      logic [4*N-1:0] got;
      rst_n = 1'b0;
      raw0  = '0;
      raw1  = '0;
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         got = dut_vec(0);
         checks++;
         if (got !== 8'h00) begin
            errs++;
            $display("FAIL reset_idle edge %0d: got %b expected %b", e, got, 8'h00);
         end
      end
   endtask

   task automatic settle_idle(int n);
      logic [4*N-1:0] got;
      for (int e = 0; e < n; e++) begin
         tick();
         got = dut_vec(0);
         checks++;
         if (got !== model_vec(0)) begin
            errs++;
            $display("FAIL idle_model: got %b expected %b", got, model_vec(0));
         end
      end
   endtask

   task automatic test_single_rise();
      logic [4*N-1:0] got, exp;
      raw0[0] = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp = {1'b0, (e >= 6), 1'b0, (e == 6), 2'b00, 1'b0, (e >= 3 && e <= 5)};
         got = dut_vec(0);
         checks++;
         if (got !== exp || got !== model_vec(0)) begin
            errs++;
            $display("FAIL single_rise edge %0d: got %b expected %b model %b", e, got, exp, model_vec(0));
         end
      end
      raw0[0] = 1'b0;
      settle_idle(10);
   endtask

   task automatic test_bounce();
      logic [4*N-1:0] got;
      raw0[1] = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         if (e == 4) raw0[1] = 1'b0;
         tick();
         got = dut_vec(0);
         checks++;
         if (got[7] !== 1'b0 || got[5] !== 1'b0 || got[3] !== 1'b0 || got !== model_vec(0)) begin
            errs++;
            $display("FAIL bounce edge %0d: got %b model %b", e, got, model_vec(0));
         end
      end
      checks++;
      if (settle0[1] !== 1'b0) begin
         errs++;
         $display("FAIL bounce_settling_end: got %b expected 0", settle0[1]);
      end
   endtask

   task automatic test_both();
      logic [4*N-1:0] got, exp;
      raw0 = 2'b11;
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp = {{2{e >= 6}}, {2{e == 6}}, 2'b00, {2{e >= 3 && e <= 5}}};
         got = dut_vec(0);
         checks++;
         if (got !== exp) begin
            errs++;
            $display("FAIL both_rise edge %0d: got %b expected %b", e, got, exp);
         end
      end
      raw0 = 2'b00;
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp = {{2{e < 6}}, 2'b00, {2{e == 6}}, {2{e >= 3 && e <= 5}}};
         got = dut_vec(0);
         checks++;
         if (got !== exp || got !== model_vec(0)) begin
            errs++;
            $display("FAIL both_fall edge %0d: got %b expected %b", e, got, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [4*N-1:0] got, exp;
      raw0[0] = 1'b1;
      repeat (4) tick();
      checks++;
      if (settle0[0] !== 1'b1) begin
         errs++;
         $display("FAIL pre_reset_settling: got %b expected 1", settle0[0]);
      end
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      got = dut_vec(0);
      checks++;
      if (got !== 8'h00) begin
         errs++;
         $display("FAIL async_reset_immediate: got %b expected %b", got, 8'h00);
      end
      #1 rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp = {1'b0, (e >= 6), 1'b0, (e == 6), 2'b00, 1'b0, (e >= 3 && e <= 5)};
         got = dut_vec(0);
         checks++;
         if (got !== exp || got !== model_vec(0)) begin
            errs++;
            $display("FAIL post_reset_rise edge %0d: got %b expected %b", e, got, exp);
         end
      end
      raw0[0] = 1'b0;
      settle_idle(10);
   endtask

   task automatic test_deb1();
      logic [4*N-1:0] got, exp;
      raw1[0] = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         exp = {1'b0, (e >= 3), 1'b0, (e == 3), 4'b0000};
         got = dut_vec(1);
         checks++;
         if (got !== exp || got !== model_vec(1)) begin
            errs++;
            $display("FAIL deb1_rise edge %0d: got %b expected %b", e, got, exp);
         end
      end
      raw1[0] = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         tick();
         exp = {1'b0, (e < 3), 2'b00, 1'b0, (e == 3), 2'b00};
         got = dut_vec(1);
         checks++;
         if (got !== exp) begin
            errs++;
            $display("FAIL deb1_fall edge %0d: got %b expected %b", e, got, exp);
         end
      end
   endtask

   task automatic test_random();
      int hold [2][N];
      logic [4*N-1:0] got;
      for (int i = 0; i < 2; i++)
         for (int c = 0; c < N; c++) hold[i][c] = 0;
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < 2; i++)
            for (int c = 0; c < N; c++) begin
               if (hold[i][c] == 0) begin
                  if (i == 0) raw0[c] = 1'($urandom_range(0, 1));
                  else        raw1[c] = 1'($urandom_range(0, 1));
                  hold[i][c] = $urandom_range(1, 7);
               end
               hold[i][c]--;
            end
         tick();
         for (int i = 0; i < 2; i++) begin
            got = dut_vec(i);
            checks++;
            if (got !== model_vec(i) || (got[5:4] & got[3:2]) !== 2'b00) begin
               errs++;
               $display("FAIL random inst %0d step %0d: got %b expected %b", i, t, got, model_vec(i));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_rise();
      test_bounce();
      test_both();
      test_async_reset();
      test_deb1();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
`default_nettype wire
